// File: rtl/param_store.sv
// Record store feeding the parameter fetch stage: parameter/state arrays with a
// push-advanced, randomly redirectable current pointer and registered outputs.
module param_store #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          re_seq_i,
  input  logic          re_ran_i,
  input  logic [AW-1:0] r_addr_i,
  input  logic          push_i,
  input  logic [31:0]   push_data_i,
  input  logic [AW-1:0] push_parent_i,
  input  logic          we_state_i,
  input  logic [AW-1:0] w_state_addr_i,
  input  logic [4:0]    w_position_i,
  input  logic          w_over_i,
  output logic [AW-1:0] addr_o,
  output logic [31:0]   data_o,
  output logic [17:0]   state_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          overflow_o
);

  logic [31:0] data_mem  [DEPTH];
  logic [17:0] state_mem [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cur_ptr_q, cur_ptr_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   data_q, data_d;
  logic [17:0]   state_q, state_d;

  logic [AW-1:0] wr_addr;
  logic          full;
  logic          push_acc;
  logic          upd_ok;
  logic [17:0]   push_state;
  logic [17:0]   upd_state;

  assign wr_addr    = wr_ptr_q[AW-1:0];
  assign full       = (wr_ptr_q == (AW+1)'(DEPTH));
  assign push_acc   = push_i && !full && !clear;
  // A push and an update can never legally target the same slot (update needs
  // addr < wr_ptr), but the push is given priority explicitly anyway.
  assign upd_ok     = we_state_i && !clear && ({1'b0, w_state_addr_i} < wr_ptr_q)
                      && !(push_acc && (w_state_addr_i == wr_addr));
  assign push_state = {5'd0, 12'(push_parent_i), 1'b0};
  assign upd_state  = {w_position_i, state_mem[w_state_addr_i][12:1], w_over_i};

  always_comb begin
    cur_ptr_d  = cur_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (clear) begin
      cur_ptr_d  = '0;
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_i && full) overflow_d = 1'b1;
      if (push_acc) begin
        cur_ptr_d = wr_addr;
        wr_ptr_d  = wr_ptr_q + (AW+1)'(1);
      end else if (re_ran_i) begin
        cur_ptr_d = r_addr_i;
      end else if (re_seq_i) begin
        cur_ptr_d = cur_ptr_q;
      end
    end
  end

  // Write-first forwarding so same-cycle writes show up on the registered outputs.
  always_comb begin
    data_d  = data_mem[cur_ptr_d];
    state_d = state_mem[cur_ptr_d];
    if (clear) begin
      data_d  = '0;
      state_d = '0;
    end else if (push_acc && (cur_ptr_d == wr_addr)) begin
      data_d  = push_data_i;
      state_d = push_state;
    end else if (upd_ok && (cur_ptr_d == w_state_addr_i)) begin
      state_d = upd_state;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      data_mem[wr_addr]  <= push_data_i;
      state_mem[wr_addr] <= push_state;
    end
    if (upd_ok) state_mem[w_state_addr_i] <= upd_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      cur_ptr_q  <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
      state_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cur_ptr_q  <= cur_ptr_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      state_q    <= state_d;
    end
  end

  assign addr_o     = cur_ptr_q;
  assign data_o     = data_q;
  assign state_o    = state_q;
  assign count_o    = wr_ptr_q;
  assign full_o     = full;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_param_store.sv
// Directed plus randomized checks of param_store against a record-level model.
module tb_param_store;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          re_seq_i;
  logic          re_ran_i;
  logic [AW-1:0] r_addr_i;
  logic          push_i;
  logic [31:0]   push_data_i;
  logic [AW-1:0] push_parent_i;
  logic          we_state_i;
  logic [AW-1:0] w_state_addr_i;
  logic [4:0]    w_position_i;
  logic          w_over_i;
  logic [AW-1:0] addr_o;
  logic [31:0]   data_o;
  logic [17:0]   state_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          overflow_o;

  param_store #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .re_seq_i(re_seq_i), .re_ran_i(re_ran_i),
    .r_addr_i(r_addr_i), .push_i(push_i), .push_data_i(push_data_i),
    .push_parent_i(push_parent_i), .we_state_i(we_state_i), .w_state_addr_i(w_state_addr_i),
    .w_position_i(w_position_i), .w_over_i(w_over_i), .addr_o(addr_o), .data_o(data_o),
    .state_o(state_o), .count_o(count_o), .full_o(full_o), .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: records as plain fields, pointers as integers.
  int unsigned m_wr, m_cur;
  bit          m_ovf, m_zero;
  logic [31:0] m_data [DEPTH];
  int unsigned m_pos  [DEPTH];
  int unsigned m_par  [DEPTH];
  bit          m_over [DEPTH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    clear = 0; re_seq_i = 0; re_ran_i = 0; r_addr_i = '0; push_i = 0;
    push_data_i = '0; push_parent_i = '0; we_state_i = 0; w_state_addr_i = '0;
    w_position_i = '0; w_over_i = 0;
  endtask

  task automatic model_reset();
    m_wr = 0; m_cur = 0; m_ovf = 0; m_zero = 1;
  endtask

  task automatic model_step();
    int unsigned wr_old;
    bit pushed;
    wr_old = m_wr;
    pushed = 0;
    if (clear) begin
      model_reset();
    end else begin
      if (push_i) begin
        if (m_wr == DEPTH) m_ovf = 1;
        else begin
          m_data[m_wr] = push_data_i;
          m_pos[m_wr]  = 0;
          m_par[m_wr]  = push_parent_i;
          m_over[m_wr] = 0;
          pushed = 1;
          m_wr++;
        end
      end
      if (we_state_i && w_state_addr_i < wr_old && !(pushed && w_state_addr_i == wr_old)) begin
        m_pos[w_state_addr_i]  = w_position_i;
        m_over[w_state_addr_i] = w_over_i;
      end
      if (pushed) m_cur = wr_old;
      else if (re_ran_i) m_cur = r_addr_i;
      m_zero = 0;
    end
  endtask

  task automatic check_outputs();
    logic [17:0] es;
    check_eq("addr", 64'(addr_o), 64'(m_cur));
    check_eq("count", 64'(count_o), 64'(m_wr));
    check_eq("full", 64'(full_o), 64'(m_wr == DEPTH));
    check_eq("overflow", 64'(overflow_o), 64'(m_ovf));
    if (m_zero) begin
      check_eq("data_zero", 64'(data_o), 64'd0);
      check_eq("state_zero", 64'(state_o), 64'd0);
    end else if (m_cur < m_wr) begin
      es = {5'(m_pos[m_cur]), 12'(m_par[m_cur]), m_over[m_cur]};
      check_eq("data", 64'(data_o), 64'(m_data[m_cur]));
      check_eq("state", 64'(state_o), 64'(es));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    idle_inputs();
  endtask

  task automatic do_push(input logic [31:0] d, input logic [AW-1:0] par);
    push_i = 1; push_data_i = d; push_parent_i = par;
    cycle();
  endtask

  task automatic do_ran(input logic [AW-1:0] a);
    re_ran_i = 1; r_addr_i = a;
    cycle();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1;

    do_push(32'h01020304, 2'd0);
    check_eq("first_push_data", 64'(data_o), 64'h01020304);
    check_eq("first_push_count", 64'(count_o), 64'd1);
    do_push(32'hA1B2C3D4, 2'd0);
    do_push(32'h55667788, 2'd1);
    do_ran(2'd1);
    check_eq("ran1_data", 64'(data_o), 64'hA1B2C3D4);
    check_eq("ran1_parent", 64'(state_o[12:1]), 64'd0);

    do_ran(2'd2);
    we_state_i = 1; w_state_addr_i = 2'd2; w_position_i = 5'd7; w_over_i = 1;
    cycle();
    check_eq("upd_cur_state", 64'(state_o), 64'hE003);
    re_seq_i = 1;
    cycle();
    check_eq("seq_hold_state", 64'(state_o), 64'hE003);

    push_i = 1; push_data_i = 32'hCAFEF00D; push_parent_i = 2'd2;
    re_ran_i = 1; r_addr_i = 2'd0;
    cycle();
    check_eq("push_beats_ran", 64'(addr_o), 64'd3);

    do_push(32'hDEADBEEF, 2'd3);
    check_eq("full_flag", 64'(full_o), 64'd1);
    check_eq("ovf_flag", 64'(overflow_o), 64'd1);
    check_eq("full_count", 64'(count_o), 64'd4);
    for (int i = 0; i < 4; i++) do_ran(2'(i));
    cycle();
    check_eq("ovf_sticky", 64'(overflow_o), 64'd1);

    clear = 1;
    cycle();
    check_eq("clear_count", 64'(count_o), 64'd0);
    check_eq("clear_ovf", 64'(overflow_o), 64'd0);

    do_push(32'h12345678, 2'd0);
    push_i = 1; push_data_i = 32'h87654321; push_parent_i = 2'd1;
    #3;
    rst_n = 0;
    #1;
    model_reset();
    check_eq("async_rst_count", 64'(count_o), 64'd0);
    check_eq("async_rst_data", 64'(data_o), 64'd0);
    check_eq("async_rst_addr", 64'(addr_o), 64'd0);
    @(posedge clk); #1;
    check_outputs();
    idle_inputs();
    rst_n = 1;
    cycle();
    check_eq("post_rst_count", 64'(count_o), 64'd0);

    for (int n = 0; n < 1500; n++) begin
      clear          = ($urandom_range(0, 99) < 2);
      push_i         = ($urandom_range(0, 99) < 35);
      push_data_i    = $urandom;
      push_parent_i  = 2'($urandom_range(0, 3));
      re_ran_i       = ($urandom_range(0, 99) < 30);
      r_addr_i       = 2'($urandom_range(0, 3));
      re_seq_i       = !re_ran_i && ($urandom_range(0, 1) == 1);
      we_state_i     = ($urandom_range(0, 99) < 40);
      w_state_addr_i = 2'($urandom_range(0, 3));
      w_position_i   = 5'($urandom_range(0, 31));
      w_over_i       = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/param_store.md
# param_store

Storage stage directly upstream of the parameter fetch stage. It holds the inexact-recursion parameter records (i, z, k, l) and their per-record state word {position, parent address, over}. It keeps a current-record pointer that is advanced by pushes and redirected by random reads. Every cycle it presents the current record's address, parameters and state, registered, to the fetch stage.

## Interface
- DEPTH, 4096: number of records; must be ≤ 2^AW.
- AW, 12: address width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous soft clear of pointers and flags.
- re_seq_i  in  1  sequential read: hold and re-present the current record.
- re_ran_i  in  1  random read: move the current pointer to r_addr_i.
- r_addr_i  in  AW  random read address.
- push_i  in  1  append a new record.
- push_data_i  in  32  {i[31:24], z[23:16], k[15:8], l[7:0]}.
- push_parent_i  in  AW  parent address stored with the new record.
- we_state_i  in  1  update the state of an existing record.
- w_state_addr_i  in  AW  record to update.
- w_position_i  in  5  new position.
- w_over_i  in  1  new over flag.
- addr_o  out  AW  current record address.
- data_o  out  32  current record parameters.
- state_o  out  18  {position[17:13], parent[12:1], over[0]} of the current record.
- count_o  out  AW+1  records stored (write pointer).
- full_o  out  1  count_o == DEPTH.
- overflow_o  out  1  sticky: a push was attempted while full.

## Operation
- Storage: DEPTH×32 parameter array and DEPTH×18 state array. Arrays are not reset. Pointers and outputs are reset.
- Registers: wr_ptr (AW+1 bits) and cur_ptr (AW bits).
- cur_next priority, evaluated each cycle:
  - clear → 0.
  - push accepted → wr_ptr.
  - re_ran_i → r_addr_i.
  - otherwise cur_ptr (covers re_seq_i and idle).
- Push accepted when push_i && !full_o.
  - Writes data at wr_ptr and state {5'd0, push_parent_i, 1'b0}.
  - Then wr_ptr += 1.
- Push while full: no write, no pointer change, overflow_o ← 1. overflow_o stays set until clear or reset.
- State update: when we_state_i && w_state_addr_i < wr_ptr, writes {w_position_i, stored parent, w_over_i}. The parent field is never rewritten. Updates at addresses ≥ wr_ptr are ignored.
- Push and state update to the same address in one cycle: the push wins.
- Output registers load each edge:
  - addr_o ← cur_next.
  - data_o and state_o ← the record at cur_next, including writes made in the same cycle (write-first forwarding).
- clear: wr_ptr, cur_ptr, outputs and overflow_o → 0. Array contents are left unchanged.
- A random read with r_addr_i ≥ wr_ptr is allowed. The data presented is undefined; the bench does not check it.

## Timing
- Reset (asynchronous assert, synchronous release): addr_o=0, data_o=0, state_o=0, count_o=0, full_o=0, overflow_o=0, cur_ptr=0.
- Read latency: 1 cycle. Request at edge N, data valid after edge N+1.
- Push latency: the pushed record appears on the outputs after the accepting edge. count_o increments at the same edge.
- State update visibility:
  - Update to cur_next: visible after the same edge.
  - Update to another address: visible on the next read of that address.
- full_o is combinational from wr_ptr, so it is valid in the cycle after the push that fills the store.
- Reset mid-operation: outputs go to 0 immediately. A write in flight is discarded.

## Test plan
- Reset, then push 0x01020304 with parent 0 → after 1 edge: addr_o=0, data_o=0x01020304, state_o=0, count_o=1.
- Push 3 records (parents 0,0,1), then re_ran_i with r_addr_i=1 → addr_o=1, data_o=record1, state_o[12:1]=0.
- we_state_i on addr 2 (position 7, over 1) while current is 2 → next cycle state_o={5'd7, 12'd1, 1'b1}. A later re_seq_i holds that value.
- Push and re_ran_i in the same cycle → addr_o equals the pushed address; the random read is ignored.
- With DEPTH=4: fill, push again → full_o=1, overflow_o=1, count_o=4, no record changed. Then clear → all flags and pointers 0.
- Assert rst_n low mid-push → outputs 0 asynchronously. After release, count_o=0.
